fact_result_serializer: RTL and testbench

- Downstream stage of the 2*factorial result register.
- Accepts 32-bit result words over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out on a single-bit framed serial line: start, data LSB-first, optional parity, stop.
- Feeds the off-block debug/UART-style link; decouples the result producer from the slow serial link.

---
 rtl/fact_result_serializer.sv | 216 +++++++++++++++++++++
 tb/tb_fact_result_serializer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fact_result_serializer.sv
// Result-word serializer: a DEPTH-entry FIFO feeding a framed LSB-first serial line (start, data, stop).
// Define FACT_SER_PARITY_EN to insert an even-parity bit between the data and the stop bit.
module fact_result_serializer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int BIT_DIV = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     ser_out,
    output logic                     ser_busy,
    output logic                     frame_done,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(BIT_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(WIDTH - 1);
    localparam logic [LW-1:0] L_FULL = LW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef FACT_SER_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

`ifdef FACT_SER_PARITY_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    state_t             state_r;
    logic [TW-1:0]      timer_r;
    logic [IW-1:0]      bit_idx_r;
    logic [WIDTH-1:0]   sr_r;
`ifdef FACT_SER_PARITY_EN
    logic               par_r;
`endif
    logic               ser_out_r;
    logic               ser_busy_r;
    logic               frame_done_r;

    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [LW-1:0]      level_r;
    logic               ready_r;

    logic               wr_s;
    logic               pop_s;
    logic               bit_end_s;
    logic [LW-1:0]      level_next_s;
    logic [WIDTH-1:0]   head_s;

    assign wr_s      = in_valid && ready_r;
    assign bit_end_s = (timer_r == T_LAST);
    assign head_s    = mem_r[rd_ptr_r];

    assign in_ready   = ready_r;
    assign ser_out    = ser_out_r;
    assign ser_busy   = ser_busy_r;
    assign frame_done = frame_done_r;
    assign fifo_level = level_r;

    // Pop the FIFO head when idle, or at the very end of a stop bit for back-to-back frames.
    always_comb begin
        pop_s = 1'b0;
        if (level_r != {LW{1'b0}}) begin
            case (state_r)
                S_IDLE:  pop_s = 1'b1;
                S_STOP:  pop_s = bit_end_s;
                default: pop_s = 1'b0;
            endcase
        end else begin
            pop_s = 1'b0;
        end
    end

    // Next FIFO occupancy; a simultaneous write and pop leaves it unchanged.
    always_comb begin
        level_next_s = level_r;
        case ({wr_s, pop_s})
            2'b10:   level_next_s = level_r + LW'(1);
            2'b01:   level_next_s = level_r - LW'(1);
            default: level_next_s = level_r;
        endcase
    end

    // FIFO storage, pointers, occupancy and registered ready (no look-ahead on a same-cycle pop).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {LW{1'b0}};
            ready_r  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= in_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            level_r <= level_next_s;
            ready_r <= (level_next_s != L_FULL);
        end
    end

    // Framing FSM; line outputs are registered from the current state so they trail it by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            timer_r      <= {TW{1'b0}};
            bit_idx_r    <= {IW{1'b0}};
            sr_r         <= {WIDTH{1'b0}};
`ifdef FACT_SER_PARITY_EN
            par_r        <= 1'b0;
`endif
            ser_out_r    <= 1'b1;
            ser_busy_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            ser_busy_r   <= (state_r != S_IDLE);
            frame_done_r <= (state_r == S_STOP) && bit_end_s;
            case (state_r)
                S_IDLE: begin
                    ser_out_r <= 1'b1;
                    timer_r   <= {TW{1'b0}};
                    if (pop_s) begin
                        sr_r    <= head_s;
`ifdef FACT_SER_PARITY_EN
                        par_r   <= even_parity(head_s);
`endif
                        state_r <= S_START;
                    end
                end
                S_START: begin
                    ser_out_r <= 1'b0;
                    if (bit_end_s) begin
                        timer_r   <= {TW{1'b0}};
                        bit_idx_r <= {IW{1'b0}};
                        state_r   <= S_DATA;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                S_DATA: begin
                    ser_out_r <= sr_r[0];
                    if (bit_end_s) begin
                        timer_r <= {TW{1'b0}};
                        sr_r    <= sr_r >> 1;
                        if (bit_idx_r == I_LAST) begin
`ifdef FACT_SER_PARITY_EN
                            state_r <= S_PARITY;
`else
                            state_r <= S_STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + IW'(1);
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
`ifdef FACT_SER_PARITY_EN
                S_PARITY: begin
                    ser_out_r <= par_r;
                    if (bit_end_s) begin
                        timer_r <= {TW{1'b0}};
                        state_r <= S_STOP;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    ser_out_r <= 1'b1;
                    if (bit_end_s) begin
                        timer_r <= {TW{1'b0}};
                        if (pop_s) begin
                            sr_r    <= head_s;
`ifdef FACT_SER_PARITY_EN
                            par_r   <= even_parity(head_s);
`endif
                            state_r <= S_START;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                default: begin
                    ser_out_r <= 1'b1;
                    timer_r   <= {TW{1'b0}};
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fact_result_serializer.sv
// Directed bench for fact_result_serializer: table of single-word frames plus burst, BIT_DIV=3,
// mid-frame reset and same-cycle write/pop sequences.
module tb_fact_result_serializer;
    localparam int W = 32;
`ifdef FACT_SER_PARITY_EN
    localparam int FL = W + 3;
`else
    localparam int FL = W + 2;
`endif

    typedef struct {
        logic [W-1:0] data;
        logic         par;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data, in_data3;
    logic         in_valid, in_valid3;
    logic         in_ready, in_ready3;
    logic         ser_out, ser_out3;
    logic         ser_busy, ser_busy3;
    logic         frame_done, frame_done3;
    logic [2:0]   fifo_level, fifo_level3;

    int errors = 0;
    int checks = 0;

    vec_t vecs [6];
    vec_t burst [6];

    always #5 clk = ~clk;

    fact_result_serializer #(.WIDTH(W), .DEPTH(4), .BIT_DIV(1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ser_out(ser_out), .ser_busy(ser_busy), .frame_done(frame_done), .fifo_level(fifo_level)
    );

    fact_result_serializer #(.WIDTH(W), .DEPTH(4), .BIT_DIV(3)) dut3 (
        .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .ser_out(ser_out3), .ser_busy(ser_busy3), .frame_done(frame_done3), .fifo_level(fifo_level3)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected line pattern, bit 0 first on the wire.
    function automatic logic [FL-1:0] exp_frame(input vec_t v);
        logic [FL-1:0] f;
        f = '0;
        for (int i = 0; i < W; i++) f[i+1] = v.data[i];
`ifdef FACT_SER_PARITY_EN
        f[W+1] = v.par;
`endif
        f[FL-1] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [W-1:0] d, input int budget, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        while (!ok && waited < budget) begin
            if (in_ready) ok = 1'b1;
            @(negedge clk);
            waited++;
        end
        in_valid = 1'b0;
    endtask

    task automatic recv(input int budget, output logic [FL-1:0] bits, output int gap,
                        output int done_pos, output int done_cnt, output bit busy, output bit ok);
        ok = 1'b0; gap = 0; done_pos = -1; done_cnt = 0; bits = '0; busy = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            gap++;
            if (ser_out == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            busy = ser_busy;
            for (int i = 0; i < FL; i++) begin
                if (i > 0) @(negedge clk);
                bits[i] = ser_out;
                if (frame_done) begin
                    done_cnt++;
                    if (done_pos < 0) done_pos = i;
                end
            end
        end
    endtask

    task automatic check_frame(input string name, input vec_t v, input int exp_gap);
        logic [FL-1:0] bits;
        int gap, dpos, dcnt;
        bit busy, ok;
        recv(200, bits, gap, dpos, dcnt, busy, ok);
        chk({name, "_start"}, ok, 1'b1);
        chk({name, "_bits"}, bits, exp_frame(v));
        chk({name, "_gap"}, gap, exp_gap);
        chk({name, "_done_pos"}, dpos, FL - 1);
        chk({name, "_done_cnt"}, dcnt, 1);
        chk({name, "_busy"}, busy, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int waited;
        logic [3*FL-1:0] s3;
        logic [FL-1:0] e3;
        int dpos3, dcnt3;
        vec_t v3;

        vecs[0] = '{32'h0000_0030, 1'b0};
        vecs[1] = '{32'h0000_0001, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{32'h8000_0000, 1'b1};
        vecs[4] = '{32'hA5A5_A5A5, 1'b0};
        vecs[5] = '{32'h0001_3B00, 1'b0};
        burst[0] = '{32'h0000_0001, 1'b1};
        burst[1] = '{32'h0000_0002, 1'b1};
        burst[2] = '{32'h0000_0004, 1'b1};
        burst[3] = '{32'h0000_000C, 1'b0};
        burst[4] = '{32'h0000_0030, 1'b0};
        burst[5] = '{32'h0000_00F0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_valid3 = 1'b0; in_data = '0; in_data3 = '0;
        #2;
        chk("rst_ser_out", ser_out, 1'b1);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", ser_busy, 1'b0);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_ser_out3", ser_out3, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Quiet line after reset release.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle", {ser_out, ser_busy, in_ready, frame_done, fifo_level},
                {1'b1, 1'b0, 1'b1, 1'b0, 3'd0});
        end

        // Single-word frames from the table.
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, 10, ok, waited);
            chk($sformatf("v%0d_accept", i), ok, 1'b1);
            check_frame($sformatf("v%0d", i), vecs[i], 2);
            @(negedge clk);
            chk($sformatf("v%0d_after", i), {ser_out, ser_busy, fifo_level}, {1'b1, 1'b0, 3'd0});
        end

        // Warm-up frame keeps the FSM busy while a 5-word burst fills the FIFO.
        send(burst[0].data, 10, ok, waited);
        chk("warm_accept", ok, 1'b1);
        fork
            begin
                for (int i = 0; i < 6; i++)
                    check_frame($sformatf("burst%0d", i), burst[i], (i == 0) ? 2 : 1);
            end
            begin
                bit bok;
                int bw;
                for (int i = 1; i < 5; i++) begin
                    send(burst[i].data, 10, bok, bw);
                    chk($sformatf("burst_acc%0d", i), bok, 1'b1);
                end
                chk("full_level", fifo_level, 3'd4);
                chk("full_ready", in_ready, 1'b0);
                send(burst[5].data, 100, bok, bw);
                chk("fifth_accept", bok, 1'b1);
                chk("fifth_blocked", bw > 10, 1'b1);
            end
        join
        @(negedge clk);
        chk("burst_after", {ser_out, ser_busy, fifo_level}, {1'b1, 1'b0, 3'd0});

        // Write coinciding with the end-of-stop pop at level 1.
        @(negedge clk);
        in_data = vecs[0].data; in_valid = 1'b1;
        chk("sim_ready_a", in_ready, 1'b1);
        @(negedge clk);
        in_data = vecs[1].data;
        chk("sim_ready_b", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("sim_level_b", fifo_level, 3'd1);
        repeat (FL - 1) @(negedge clk);
        chk("sim_level_pre", fifo_level, 3'd1);
        chk("sim_ready_c", in_ready, 1'b1);
        in_data = vecs[5].data; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("sim_done_a", frame_done, 1'b1);
        chk("sim_level_post", fifo_level, 3'd1);
        check_frame("sim_b", vecs[1], 1);
        check_frame("sim_c", vecs[5], 1);
        @(negedge clk);
        chk("sim_after", {ser_out, ser_busy, fifo_level}, {1'b1, 1'b0, 3'd0});

        // Reset in the middle of data bit 10 with two words still queued.
        send(32'h0000_0000, 10, ok, waited);
        send(32'h0000_0005, 10, ok, waited);
        send(32'h0000_0006, 10, ok, waited);
        repeat (9) @(negedge clk);
        chk("mid_bit10", {ser_out, ser_busy, fifo_level}, {1'b0, 1'b1, 3'd2});
        #1 reset = 1'b1;
        #1;
        chk("mid_rst", {ser_out, ser_busy, fifo_level, frame_done, in_ready},
            {1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_hold", {ser_out, frame_done}, {1'b1, 1'b0});
        end
        reset = 1'b0;
        @(negedge clk);
        chk("mid_release", {in_ready, fifo_level, frame_done}, {1'b1, 3'd0, 1'b0});
        send(vecs[1].data, 10, ok, waited);
        chk("mid_accept", ok, 1'b1);
        check_frame("mid_new", vecs[1], 2);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("mid_quiet", {ser_out, ser_busy, frame_done}, {1'b1, 1'b0, 1'b0});
        end

        // BIT_DIV=3: every bit held exactly three cycles.
        v3 = '{32'h0000_9D80, 1'b0};
        e3 = exp_frame(v3);
        @(negedge clk);
        in_data3 = v3.data; in_valid3 = 1'b1;
        chk("bd3_ready", in_ready3, 1'b1);
        @(negedge clk);
        in_valid3 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ser_out3 == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bd3_start", ok, 1'b1);
        dpos3 = -1; dcnt3 = 0; s3 = '0;
        for (int i = 0; i < 3 * FL; i++) begin
            if (i > 0) @(negedge clk);
            s3[i] = ser_out3;
            if (frame_done3) begin
                dcnt3++;
                if (dpos3 < 0) dpos3 = i;
            end
        end
        for (int b = 0; b < FL; b++)
            chk($sformatf("bd3_bit%0d", b), {s3[3*b], s3[3*b+1], s3[3*b+2]}, {3{e3[b]}});
        chk("bd3_done_pos", dpos3, 3 * FL - 1);
        chk("bd3_done_cnt", dcnt3, 1);
        @(negedge clk);
        chk("bd3_after", {ser_out3, ser_busy3, frame_done3}, {1'b1, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
